// File: rtl/spi_apb_bridge.sv
// rtl/spi_apb_bridge.sv - APB3 slave feeding an SPI mode-0 master driver through TX/RX byte FIFOs
//
// Purpose:
//   Register front end for spi_master_driver. TX bytes written over APB are
//   queued and issued one start_o pulse per byte; each received byte is pushed
//   into an RX queue read back through DATA. Chip select comes from CTRL[0].
//
// Optional feature (macro SPI_BRIDGE_IRQ_EN):
//   adds IRQ_EN register at 0xC and the level interrupt output irq_o.
//
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous reset, active low
//   psel_i       APB select
//   penable_i    APB enable
//   pwrite_i     APB write
//   paddr_bi     byte address, [3:2] decoded
//   pwdata_bi    APB write data
//   prdata_bo    APB read data, 0 outside an access
//   pready_o     always 1
//   start_o      1-cycle start pulse to the driver
//   tx_byte_bo   byte for the driver, stable until the next pop
//   busy_i       driver busy
//   rx_byte_bi   byte received by the driver
//   spi_cs_o     active-low chip select
//   irq_o        level interrupt (SPI_BRIDGE_IRQ_EN only)

module spi_apb_bridge_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [7:0]               wdata_bi,
  input  logic                     pop_i,
  output logic [7:0]               rdata_bo,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_bo
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_o   = (count_bo == FULL_CNT);
  assign empty_o  = (count_bo == '0);
  // Push into a full queue and pop from an empty one are silently ignored here;
  // the parent decides whether that is an overflow.
  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  assign rdata_bo = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_bi;
  end

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_bo <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_bo <= count_bo + 1'b1;
        2'b01:   count_bo <= count_bo - 1'b1;
        default: count_bo <= count_bo;
      endcase
    end
  end

endmodule

module spi_apb_bridge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [3:0]  paddr_bi,
  input  logic [31:0] pwdata_bi,
  output logic [31:0] prdata_bo,
  output logic        pready_o,
  output logic        start_o,
  output logic [7:0]  tx_byte_bo,
  input  logic        busy_i,
  input  logic [7:0]  rx_byte_bi,
  output logic        spi_cs_o
`ifdef SPI_BRIDGE_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_IRQ  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_CAPT
  } state_t;

  state_t        state;

  logic          access;
  logic          wr_en;
  logic          rd_en;
  logic [1:0]    reg_sel;

  logic          tx_push;
  logic          tx_pop;
  logic [7:0]    tx_head;
  logic          tx_full;
  logic          tx_empty;
  logic [CW-1:0] tx_count;

  logic          rx_push;
  logic          rx_pop;
  logic [7:0]    rx_head;
  logic          rx_full;
  logic          rx_empty;
  logic [CW-1:0] rx_count;

  logic [1:0]    ctrl_q;
  logic          tx_ovf;
  logic          rx_ovf;
  logic          busy;
  logic [31:0]   stat_w;
  logic          unused_bits;

`ifdef SPI_BRIDGE_IRQ_EN
  logic [2:0]    irq_en;
`endif

  assign access   = psel_i & penable_i;
  assign wr_en    = access & pwrite_i;
  assign rd_en    = access & ~pwrite_i;
  assign reg_sel  = paddr_bi[3:2];
  assign pready_o = 1'b1;
  assign spi_cs_o = ctrl_q[0];

  assign unused_bits = ^{pwdata_bi[31:8], paddr_bi[1:0], tx_count};

  assign tx_push = wr_en & (reg_sel == A_DATA);
  assign tx_pop  = (state == S_IDLE) & ctrl_q[1] & ~tx_empty;
  assign rx_push = (state == S_CAPT);
  assign rx_pop  = rd_en & (reg_sel == A_DATA);

  spi_apb_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .push_i   (tx_push),
    .wdata_bi (pwdata_bi[7:0]),
    .pop_i    (tx_pop),
    .rdata_bo (tx_head),
    .full_o   (tx_full),
    .empty_o  (tx_empty),
    .count_bo (tx_count)
  );

  spi_apb_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .push_i   (rx_push),
    .wdata_bi (rx_byte_bi),
    .pop_i    (rx_pop),
    .rdata_bo (rx_head),
    .full_o   (rx_full),
    .empty_o  (rx_empty),
    .count_bo (rx_count)
  );

  assign busy   = (state != S_IDLE) | ~tx_empty;
  assign stat_w = {16'b0, {(8-CW){1'b0}}, rx_count, 1'b0, tx_ovf, rx_ovf,
                   rx_empty, rx_full, tx_empty, tx_full, busy};

  // Control, sticky flags and optional interrupt enable.
  // A new overflow in the same cycle as its W1C wins, so no event is lost.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q <= 2'b01;
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
`ifdef SPI_BRIDGE_IRQ_EN
      irq_en <= 3'b000;
`endif
    end else begin
      if (wr_en && reg_sel == A_CTRL) ctrl_q <= pwdata_bi[1:0];

      if (tx_push && tx_full)
        tx_ovf <= 1'b1;
      else if (wr_en && reg_sel == A_STAT && pwdata_bi[6])
        tx_ovf <= 1'b0;

      if (rx_push && rx_full)
        rx_ovf <= 1'b1;
      else if (wr_en && reg_sel == A_STAT && pwdata_bi[5])
        rx_ovf <= 1'b0;

`ifdef SPI_BRIDGE_IRQ_EN
      if (wr_en && reg_sel == A_IRQ) irq_en <= pwdata_bi[2:0];
`endif
    end
  end

`ifdef SPI_BRIDGE_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      irq_o <= 1'b0;
    else
      irq_o <= |(irq_en & {rx_ovf | tx_ovf, tx_empty & (state == S_IDLE), ~rx_empty});
  end
`endif

  // Transfer FSM. The enable bit is only consulted in IDLE, so clearing it
  // lets the byte in flight finish and be captured.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      start_o    <= 1'b0;
      tx_byte_bo <= 8'h00;
    end else begin
      start_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_byte_bo <= tx_head;
            start_o    <= 1'b1;
            state      <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: if (busy_i)  state <= S_WAIT_LO;
        S_WAIT_LO: if (!busy_i) state <= S_CAPT;
        S_CAPT:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    prdata_bo = 32'h0;
    if (rd_en) begin
      case (reg_sel)
        A_DATA: if (!rx_empty) prdata_bo = {24'h0, rx_head};
        A_STAT: prdata_bo = stat_w;
        A_CTRL: prdata_bo = {30'h0, ctrl_q};
`ifdef SPI_BRIDGE_IRQ_EN
        A_IRQ:  prdata_bo = {29'h0, irq_en};
`endif
        default: prdata_bo = 32'h0;
      endcase
    end
  end

endmodule
